// File: rtl/tag_alloc_if.sv
// -----------------------------------------------------------------------------
// tag_alloc_if -- allocation handshake and tag-return bundle for tag_alloc.
//
// Signals (W = number of tags, TW = $clog2(W)):
//   alloc_vld  allocator -> consumer  a free tag is offered
//   alloc_tag  allocator -> consumer  offered tag, TW bits
//   alloc_rdy  consumer -> allocator  offered tag is accepted this cycle
//   free_vld   consumer -> allocator  a tag is being returned
//   free_tag   consumer -> allocator  tag being returned, TW bits
//
// Modports:
//   slave   the allocator (tag_alloc)
//   master  the consumer that takes and returns tags
// -----------------------------------------------------------------------------
interface tag_alloc_if #(
  parameter int W = 32
);
  localparam int TW = $clog2(W);

  logic          alloc_vld;
  logic [TW-1:0] alloc_tag;
  logic          alloc_rdy;
  logic          free_vld;
  logic [TW-1:0] free_tag;

  modport slave (
    output alloc_vld,
    output alloc_tag,
    input  alloc_rdy,
    input  free_vld,
    input  free_tag
  );

  modport master (
    input  alloc_vld,
    input  alloc_tag,
    output alloc_rdy,
    output free_vld,
    output free_tag
  );
endinterface

// File: rtl/tag_alloc.sv
// -----------------------------------------------------------------------------
// tag_alloc -- W-entry tag allocator with a rotating free-slot search.
//
// A busy vector records which tags are held. Each cycle the allocator offers
// the first free tag at or after a search pointer (wrapping W-1 -> 0). The
// pointer advances past every tag that is handed out, so tags are granted
// round-robin rather than always reusing the lowest free index. The offered
// candidate is registered: it is computed from the next-cycle busy vector and
// next-cycle pointer, which keeps alloc_vld/alloc_tag glitch-free and stable
// while the consumer stalls.
//
// Parameters:
//   W      number of tags, power of two, >= 2
//   INFER  1: rotator written as a plain shift; 0: explicit log2(W)-stage
//          barrel rotator
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset (overrides everything)
//   bus      tag_alloc_if.slave: alloc_vld/alloc_tag/alloc_rdy handshake and
//            free_vld/free_tag return path
//   flush_i  release every tag; beats a same-cycle grant and free
//   busy_o   held-tag vector, bit t = tag t held
//   count_o  number of held tags
//   full_o   count_o == W
//   empty_o  count_o == 0
//   err_o    sticky illegal-free flag
//
// Build option:
//   TAG_ALLOC_ERR_CHECK_EN  when defined, err_o sets the cycle after a free
//                           names a tag that is not held, and stays set until
//                           rst_i (flush does not clear it). When undefined,
//                           err_o is tied low and no check logic exists.
//                           Illegal frees are ignored either way.
// -----------------------------------------------------------------------------
module tag_alloc #(
  parameter int W     = 32,
  parameter bit INFER = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tag_alloc_if.slave           bus,
  input  logic                 flush_i,
  output logic [W-1:0]         busy_o,
  output logic [$clog2(W):0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_o
);

  localparam int TW = $clog2(W);
  localparam int CW = TW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]  busy_q,     busy_d;
  logic [TW-1:0] ptr_q,      ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          full_q,     full_d;
  logic          empty_q,    empty_d;
  logic          cand_vld_q, cand_vld_d;
  logic [TW-1:0] cand_tag_q, cand_tag_d;

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  logic fire;
  logic free_ok;

  assign fire    = cand_vld_q & bus.alloc_rdy;
  // Returning a tag that is not held is dropped; it must never clear a bit
  // or decrement the count.
  assign free_ok = bus.free_vld & busy_q[bus.free_tag];

  // ---------------------------------------------------------------------------
  // Next-state busy vector, pointer and count
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default on its first
  // line, so no path through the block leaves it unassigned and no latch is
  // inferred.
  always_comb begin
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    count_d = count_q;

    if (flush_i) begin
      // A grant that fires alongside a flush is lost: the consumer saw the
      // handshake, but the tag is not recorded as held.
      busy_d  = '0;
      ptr_d   = '0;
      count_d = '0;
    end else begin
      // The fired tag is free by construction, so it can never be the tag
      // being legally freed in the same cycle; both updates are independent.
      if (fire) begin
        busy_d[cand_tag_q] = 1'b1;
        ptr_d              = cand_tag_q + TW'(1);  // wraps mod W
      end
      if (free_ok) begin
        busy_d[bus.free_tag] = 1'b0;
      end
      count_d = count_q + CW'(fire) - CW'(free_ok);
    end
  end

  assign full_d  = (count_d == CW'(W));
  assign empty_d = (count_d == '0);

  // ---------------------------------------------------------------------------
  // Circular first-free search
  //
  // The free vector is rotated right by ptr_d so that tag ptr_d lands at bit
  // 0; a lowest-set-bit search over the rotated vector then gives the offset
  // from the pointer, and adding the pointer back (mod W) gives the tag.
  // ---------------------------------------------------------------------------
  logic [W-1:0] free_d;
  logic [W-1:0] rot_free;

  assign free_d = ~busy_d;

  if (INFER) begin : g_rot_infer
    assign rot_free = W'({free_d, free_d} >> ptr_d);
  end else begin : g_rot_explicit
    // Stage s rotates by 2**s when bit s of the pointer is set.
    logic [W-1:0] rot_stage [TW+1];

    assign rot_stage[0] = free_d;

    for (genvar s = 0; s < TW; s++) begin : g_stage
      localparam int K = 1 << s;
      assign rot_stage[s+1] = ptr_d[s]
                            ? {rot_stage[s][K-1:0], rot_stage[s][W-1:K]}
                            : rot_stage[s];
    end

    assign rot_free = rot_stage[TW];
  end

  logic [TW-1:0] first_off;

  // Scanning from the top down leaves the lowest set index as the result.
  always_comb begin
    first_off = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (rot_free[i]) begin
        first_off = TW'(i);
      end
    end
  end

  // When nothing is free the tag is a don't-care; the sum is harmless.
  assign cand_vld_d = |free_d;
  assign cand_tag_d = ptr_d + first_off;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples its inputs from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      cand_vld_q <= 1'b1;
      cand_tag_q <= '0;
    end else begin
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      cand_vld_q <= cand_vld_d;
      cand_tag_q <= cand_tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Illegal-free detection
  // ---------------------------------------------------------------------------
`ifdef TAG_ALLOC_ERR_CHECK_EN
  logic err_q;

  // Sticky: only reset clears it, a flush leaves it set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (bus.free_vld & ~busy_q[bus.free_tag]);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.alloc_vld = cand_vld_q;
  assign bus.alloc_tag = cand_tag_q;
  assign busy_o        = busy_q;
  assign count_o       = count_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;

endmodule
